// File: rtl/conv_window_scheduler.sv
// Output-window sequencer for the 3x3 depthwise conv address generator:
// raster walk of the output map with stride 1/2 and round-robin one-hot PE row tags.
module conv_window_scheduler #(
  parameter int ROW_COUNT   = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_reg_clear,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic                  i_stride,
  input  logic                  i_ready,
  output logic                  o_en,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [ROW_COUNT-1:0]  o_row_id,
  output logic                  o_busy,
  output logic                  o_done
);

  // state | meaning
  // IDLE  | waiting for i_start; size and stride latched on start
  // CALC  | one cycle computing the output side length
  // RUN   | emitting windows, one per cycle with i_ready high
  // DONE  | one-cycle o_done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, CALC, RUN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] KSIZE   = ADDR_WIDTH'(KERNEL_SIZE);
  localparam logic [ROW_COUNT-1:0]  ROW_ONE = ROW_COUNT'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] size_q;
  logic [ADDR_WIDTH-1:0] out_size;
  logic [ADDR_WIDTH-1:0] row_idx;
  logic [ADDR_WIDTH-1:0] col_idx;
  logic                  stride_q;
  logic [ROW_COUNT-1:0]  row_ptr;
  logic                  accept;
  logic                  last_col;
  logic                  last_win;

  assign accept   = (state == RUN) & i_ready;
  assign last_col = (col_idx == out_size - 1'b1);
  assign last_win = last_col & (row_idx == out_size - 1'b1);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= IDLE;
      size_q   <= '0;
      stride_q <= 1'b0;
      out_size <= '0;
      row_idx  <= '0;
      col_idx  <= '0;
      row_ptr  <= ROW_ONE;
    end else if (i_reg_clear) begin
      state    <= IDLE;
      size_q   <= '0;
      stride_q <= 1'b0;
      out_size <= '0;
      row_idx  <= '0;
      col_idx  <= '0;
      row_ptr  <= ROW_ONE;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            size_q   <= i_i_size;
            stride_q <= i_stride;
            state    <= CALC;
          end
        end
        CALC: begin
          row_idx <= '0;
          col_idx <= '0;
          row_ptr <= ROW_ONE;
          if (size_q < KSIZE) begin
            out_size <= '0;
            state    <= DONE;
          end else begin
            out_size <= ((size_q - KSIZE) >> stride_q) + 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            // Counters and pointer return to their idle values on the last
            // window so the next layer starts from (0,0) on row 0.
            if (last_win) begin
              row_idx <= '0;
              col_idx <= '0;
              row_ptr <= ROW_ONE;
              state   <= DONE;
            end else begin
              row_ptr <= {row_ptr[ROW_COUNT-2:0], row_ptr[ROW_COUNT-1]};
              if (last_col) begin
                col_idx <= '0;
                row_idx <= row_idx + 1'b1;
              end else begin
                col_idx <= col_idx + 1'b1;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_en     = accept;
  assign o_o_x    = row_idx << stride_q;
  assign o_o_y    = col_idx << stride_q;
  assign o_row_id = row_ptr;
  assign o_busy   = (state == CALC) | (state == RUN);
  assign o_done   = (state == DONE);

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Table-driven bench for conv_window_scheduler: per-cycle input/expected-output
// records plus a hand-written asynchronous reset sequence.
module tb_conv_window_scheduler;
  localparam int AW = 6;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          nrst, start, clr, stride, ready;
  logic [AW-1:0] size;
  logic          en, busy, done;
  logic [AW-1:0] ox, oy;
  logic [RC-1:0] row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_scheduler #(.ROW_COUNT(RC), .ADDR_WIDTH(AW), .KERNEL_SIZE(3)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_reg_clear(clr),
    .i_i_size(size), .i_stride(stride), .i_ready(ready),
    .o_en(en), .o_o_x(ox), .o_o_y(oy), .o_row_id(row),
    .o_busy(busy), .o_done(done)
  );

  typedef struct {
    logic          start;
    logic          clr;
    logic [AW-1:0] size;
    logic          stride;
    logic          ready;
    logic          en;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [RC-1:0] row;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic cl, int sz, logic sd, logic rd,
                              logic e, int x, int y, int r, logic b, logic d);
    vec_t t;
    t.start = st; t.clr = cl; t.size = AW'(sz); t.stride = sd; t.ready = rd;
    t.en = e; t.x = AW'(x); t.y = AW'(y); t.row = RC'(r); t.busy = b; t.done = d;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full layer: start cycle, CALC, osz*osz windows with ready high, DONE, IDLE.
  function automatic void push_layer(int sz, logic sd, int osz);
    int sh;
    sh = sd ? 1 : 0;
    tbl.push_back(mk(1, 0, sz, sd, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, sz, sd, 1, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < osz * osz; i++)
      tbl.push_back(mk(0, 0, sz, sd, 1, 1, (i / osz) << sh, (i % osz) << sh,
                       1 << (i % RC), 1, 0));
    tbl.push_back(mk(0, 0, sz, sd, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, sz, sd, 1, 0, 0, 0, 1, 0, 0));
  endfunction

  task automatic apply(vec_t t, int idx);
    start = t.start; clr = t.clr; size = t.size; stride = t.stride; ready = t.ready;
    @(negedge clk);
    check($sformatf("v%0d en", idx),   32'(en),   32'(t.en));
    check($sformatf("v%0d x", idx),    32'(ox),   32'(t.x));
    check($sformatf("v%0d y", idx),    32'(oy),   32'(t.y));
    check($sformatf("v%0d row", idx),  32'(row),  32'(t.row));
    check($sformatf("v%0d busy", idx), 32'(busy), 32'(t.busy));
    check($sformatf("v%0d done", idx), 32'(done), 32'(t.done));
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; start = 0; clr = 0; size = '0; stride = 0; ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset en",   32'(en),   0);
    check("reset x",    32'(ox),   0);
    check("reset y",    32'(oy),   0);
    check("reset row",  32'(row),  1);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    @(posedge clk);
    #1 nrst = 1'b1;

    // stride 1, 6x6 input -> 4x4 windows
    push_layer(6, 0, 4);
    // 5x5 -> 3x3, row ids wrap after four windows
    push_layer(5, 0, 3);
    // stride 2, 7x7 -> 3x3 windows at {0,2,4}; row id restarts at 0001
    push_layer(7, 1, 3);

    // backpressure, 4x4 -> 2x2, ready 1,0,0 repeating in RUN
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 1, 1, 0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 1, 1, 1, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 1, 1, 8, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 1, 1, 8, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 1, 1, 1, 1, 8, 1, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, 0, 1, 0, 0));

    // degenerate 2x2 input: CALC -> DONE, no windows
    push_layer(2, 0, 0);

    // clear after the 5th window; start during RUN is ignored
    tbl.push_back(mk(1, 0, 6, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 6, 0, 1, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(i == 2, 0, 6, 0, 1, 1, i / 4, i % 4, 1 << (i % RC), 1, 0));
    tbl.push_back(mk(0, 1, 6, 0, 1, 1, 1, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 6, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 6, 0, 1, 0, 0, 0, 1, 0, 0));
    push_layer(6, 0, 4);

    foreach (tbl[i]) apply(tbl[i], i);

    // asynchronous reset in the middle of RUN
    start = 1; size = 6; stride = 0; ready = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #2;
    check("midrst en before", 32'(en), 1);
    nrst = 1'b0;
    #1;
    check("midrst en",   32'(en),   0);
    check("midrst x",    32'(ox),   0);
    check("midrst y",    32'(oy),   0);
    check("midrst row",  32'(row),  1);
    check("midrst busy", 32'(busy), 0);
    @(posedge clk); #1 nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst idle done %0d", i), 32'(done), 0);
      check($sformatf("midrst idle en %0d", i),   32'(en),   0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
